// File: rtl/tdc_byte_reader.sv
// tdc_byte_reader: fires a TDC start pulse, walks the 2-bit byte select over all four
//   lanes with a settle delay per lane, and reassembles the 32-bit count.
// Latency: word_valid rises LAUNCH_CYCLES + 4*(SETTLE_CYCLES+1) + 1 cycles after req is taken in IDLE.
// Backpressure: word_out/word_valid/sel hold in HOLD until word_ready; req outside IDLE is dropped.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous reset (active HIGH despite the name)
//   req            measurement request, only looked at in IDLE
//   busy           high in every state except IDLE
//   start          registered TDC start strobe, high for LAUNCH_CYCLES cycles
//   sel            byte-lane select to the TDC mux (0 -> [7:0] ... 3 -> [31:24])
//   byte_in        muxed TDC byte for the current sel
//   word_out       assembled count, word_valid/word_ready handshake
//   ones_count     popcount of word_out when TDC_READ_POPCOUNT_EN is defined, else tied to 0
//
// Optional feature macro: TDC_READ_POPCOUNT_EN
module tdc_byte_reader #(
    parameter int unsigned LAUNCH_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        busy,
    output logic        start,
    output logic [1:0]  sel,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [5:0]  ones_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Counters load "cycles - 1" on entry and the state exits when they reach zero.
    localparam logic [7:0] LAUNCH_LOAD = 8'(LAUNCH_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [1:0]  sel_nxt;
    logic        capture;
    logic        load_word;

    // Lanes 0..2 are parked here; lane 3 goes straight into word_out together
    // with them, so the top byte never needs its own shadow register.
    logic [23:0] shadow;
    logic [31:0] assembled;

    assign assembled = {byte_in, shadow};
    assign busy      = (state != IDLE);
    assign load_word = capture && (sel == 2'd3);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = 2'd0;
                if (req) begin
                    state_nxt = LAUNCH;
                    cnt_nxt   = LAUNCH_LOAD;
                end
            end
            LAUNCH: begin
                if (cnt == 8'd0) begin
                    sel_nxt = 2'd0;
                    if (NO_SETTLE) begin
                        state_nxt = SAMPLE;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = SETTLE_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            SAMPLE: begin
                capture = 1'b1;
                if (sel == 2'd3) begin
                    state_nxt = HOLD;
                end else begin
                    sel_nxt = sel + 2'd1;
                    if (NO_SETTLE) begin
                        state_nxt = SAMPLE;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = SETTLE_LOAD;
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_nxt = IDLE;
                    sel_nxt   = 2'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            sel        <= 2'd0;
            start      <= 1'b0;
            word_valid <= 1'b0;
            shadow     <= 24'd0;
            word_out   <= 32'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            // Flop outputs are decoded from the next state so they line up
            // exactly with the state they belong to and cannot glitch.
            start      <= (state_nxt == LAUNCH);
            word_valid <= (state_nxt == HOLD);
            if (capture) begin
                case (sel)
                    2'd0:    shadow[7:0]   <= byte_in;
                    2'd1:    shadow[15:8]  <= byte_in;
                    2'd2:    shadow[23:16] <= byte_in;
                    default: shadow        <= shadow;
                endcase
            end
            if (load_word) begin
                word_out <= assembled;
            end
        end
    end

`ifdef TDC_READ_POPCOUNT_EN
    logic [5:0] pop_nxt;
    logic [5:0] ones_q;

    always_comb begin
        pop_nxt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            pop_nxt = pop_nxt + 6'(assembled[i]);
        end
    end

    // Loaded with word_out so the count is valid whenever word_valid is.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ones_q <= 6'd0;
        end else if (load_word) begin
            ones_q <= pop_nxt;
        end
    end

    assign ones_count = ones_q;
`else
    assign ones_count = 6'd0;
`endif

endmodule

// File: tb/tb_tdc_byte_reader.sv
`timescale 1ns/1ps
module tb_tdc_byte_reader;

    localparam int L   = 4;
    localparam int S   = 2;
    localparam int VC  = L + 4 * (S + 1) + 1;
    localparam int L2  = 1;
    localparam int S2  = 0;
    localparam int VC2 = L2 + 4 * (S2 + 1) + 1;

`ifdef TDC_READ_POPCOUNT_EN
    localparam bit POP_ON = 1'b1;
`else
    localparam bit POP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, word_ready;
    logic        busy, start, word_valid;
    logic [1:0]  sel;
    logic [7:0]  byte_in;
    logic [31:0] word_out;
    logic [5:0]  ones_count;

    logic        req2, ready2;
    logic        busy2, start2, word_valid2;
    logic [1:0]  sel2;
    logic [7:0]  byte_in2;
    logic [31:0] word_out2;
    logic [5:0]  ones2;

    int total = 0;
    int bad   = 0;

    logic [31:0] tdc_value, tdc2, prev_word;
    logic [7:0]  garbage;
    int          age;
    logic [1:0]  last_sel;

    // TDC model: the mux output is only trustworthy S cycles after a select
    // change; before that it shows random junk, so early sampling is caught.
    always @(negedge clk) begin
        if (sel !== last_sel) age = 0;
        else if (age < 1000) age = age + 1;
        last_sel = sel;
        garbage  = 8'($urandom);
    end
    assign byte_in  = (age >= S) ? tdc_value[8*sel +: 8] : garbage;
    assign byte_in2 = tdc2[8*sel2 +: 8];

    tdc_byte_reader #(.LAUNCH_CYCLES(L), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .start(start), .sel(sel),
        .byte_in(byte_in), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .ones_count(ones_count)
    );

    tdc_byte_reader #(.LAUNCH_CYCLES(L2), .SETTLE_CYCLES(S2)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req(req2), .busy(busy2), .start(start2), .sel(sel2),
        .byte_in(byte_in2), .word_out(word_out2), .word_valid(word_valid2),
        .word_ready(ready2), .ones_count(ones2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] exp_ones(input logic [31:0] w);
        return POP_ON ? 6'($countones(w)) : 6'd0;
    endfunction

    // One full read with req at relative cycle 0 (the current cycle).
    // hold: cycles word_ready stays low after valid; stray: cycle of an extra
    // req pulse (0 = none); keep_ready leaves word_ready high afterwards.
    task automatic do_read(input logic [31:0] val, input int hold, input int stray,
                           input bit keep_ready);
        tdc_value  = val;
        req        = 1'b1;
        word_ready = (hold == 0);
        for (int c = 1; c <= VC; c++) begin
            step();
            req = (c == stray);
            total++;
            if (start !== (c <= L)) begin
                bad++;
                $display("FAIL start c=%0d got=%b want=%b", c, start, (c <= L));
            end
            total++;
            if (word_valid !== (c == VC) || busy !== 1'b1) begin
                bad++;
                $display("FAIL valid_busy c=%0d valid=%b busy=%b want_valid=%b", c, word_valid, busy, (c == VC));
            end
            if (c < VC) begin
                total++;
                if (word_out !== prev_word) begin
                    bad++;
                    $display("FAIL word_hold c=%0d got=%h want=%h", c, word_out, prev_word);
                end
            end
        end
        total++;
        if (word_out !== val) begin
            bad++;
            $display("FAIL word_out got=%h want=%h", word_out, val);
        end
        total++;
        if (ones_count !== exp_ones(val)) begin
            bad++;
            $display("FAIL ones_count got=%0d want=%0d", ones_count, exp_ones(val));
        end
        total++;
        if (sel !== 2'd3) begin
            bad++;
            $display("FAIL hold_sel got=%0d want=3", sel);
        end
        for (int k = 1; k <= hold; k++) begin
            step();
            req = 1'b0;
            total++;
            if (word_valid !== 1'b1 || word_out !== val || sel !== 2'd3 || busy !== 1'b1) begin
                bad++;
                $display("FAIL backpressure k=%0d valid=%b word=%h sel=%0d want 1/%h/3", k, word_valid, word_out, sel, val);
            end
            if (k == hold) word_ready = 1'b1;
        end
        step();
        req = 1'b0;
        total++;
        if (word_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || start !== 1'b0 || word_out !== val) begin
            bad++;
            $display("FAIL after_hs valid=%b busy=%b sel=%0d start=%b word=%h want 0/0/0/0/%h", word_valid, busy, sel, start, word_out, val);
        end
        prev_word = val;
        if (!keep_ready) word_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) step();
        total++;
        if ({start, busy, word_valid, sel, word_out, ones_count} !== 41'd0) begin
            bad++;
            $display("FAIL reset_dut start=%b busy=%b valid=%b sel=%0d word=%h ones=%0d want all 0", start, busy, word_valid, sel, word_out, ones_count);
        end
        total++;
        if ({start2, busy2, word_valid2, sel2, word_out2, ones2} !== 41'd0) begin
            bad++;
            $display("FAIL reset_fast start=%b busy=%b valid=%b sel=%0d word=%h ones=%0d want all 0", start2, busy2, word_valid2, sel2, word_out2, ones2);
        end
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_read(32'h0000FF0F, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_read(32'hA1B2C3D4, 10, 0, 1'b0);
    endtask

    task automatic test_req_while_busy();
        do_read($urandom, 0, 6, 1'b0);
        // req together with word_ready in HOLD: only the handshake happens
        do_read($urandom, 0, VC, 1'b0);
        step();
        total++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            bad++;
            $display("FAIL req_in_hold busy=%b start=%b want 0/0", busy, start);
        end
    endtask

    task automatic test_reset_mid_op();
        tdc_value = $urandom;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        total++;
        if (start !== 1'b1) begin
            bad++;
            $display("FAIL mid_start got=%b want=1", start);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (start !== 1'b0 || busy !== 1'b0 || word_valid !== 1'b0 || word_out !== 32'd0 || sel !== 2'd0) begin
            bad++;
            $display("FAIL async_rst start=%b busy=%b valid=%b word=%h sel=%0d want 0", start, busy, word_valid, word_out, sel);
        end
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (word_valid !== 1'b0 || word_out !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_rst valid=%b word=%h busy=%b want 0", word_valid, word_out, busy);
        end
        prev_word = 32'd0;
        do_read($urandom, 1, 0, 1'b0);
        // reset while parked in HOLD
        tdc_value  = $urandom;
        word_ready = 1'b0;
        req = 1'b1;
        for (int c = 1; c <= VC; c++) begin
            step();
            req = 1'b0;
        end
        total++;
        if (word_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_reach got=%b want=1", word_valid);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (word_valid !== 1'b0 || word_out !== 32'd0 || sel !== 2'd0 || busy !== 1'b0 || ones_count !== 6'd0) begin
            bad++;
            $display("FAIL hold_rst valid=%b word=%h sel=%0d busy=%b ones=%0d want 0", word_valid, word_out, sel, busy, ones_count);
        end
        step();
        rst_n = 1'b0;
        step();
        prev_word = 32'd0;
    endtask

    task automatic test_fast();
        logic [31:0] vals [2];
        vals[0] = 32'hFFFFFFFF;
        vals[1] = $urandom;
        ready2  = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tdc2 = vals[n];
            req2 = 1'b1;
            for (int c = 1; c <= VC2; c++) begin
                step();
                req2 = 1'b0;
                total++;
                if (word_valid2 !== (c == VC2) || start2 !== (c <= L2)) begin
                    bad++;
                    $display("FAIL fast_timing c=%0d valid=%b start=%b want %b/%b", c, word_valid2, start2, (c == VC2), (c <= L2));
                end
            end
            total++;
            if (word_out2 !== vals[n] || ones2 !== exp_ones(vals[n])) begin
                bad++;
                $display("FAIL fast_word got=%h/%0d want=%h/%0d", word_out2, ones2, vals[n], exp_ones(vals[n]));
            end
            step();
            total++;
            if (word_valid2 !== 1'b0 || busy2 !== 1'b0) begin
                bad++;
                $display("FAIL fast_idle valid=%b busy=%b want 0/0", word_valid2, busy2);
            end
        end
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b1;
        do_read(32'h11223344, 0, 0, 1'b1);
        do_read(32'hCAFE0B0E, 0, 0, 1'b1);
        word_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            do_read($urandom, $urandom_range(0, 3), $urandom_range(0, VC), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        req        = 1'b0;
        word_ready = 1'b0;
        req2       = 1'b0;
        ready2     = 1'b1;
        tdc_value  = 32'd0;
        tdc2       = 32'd0;
        prev_word  = 32'd0;
        age        = 0;
        last_sel   = 2'd0;
        garbage    = 8'd0;
        test_reset();
        test_single();
        test_backpressure();
        test_req_while_busy();
        test_reset_mid_op();
        test_fast();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
